mem_stage: RTL and testbench

- Memory-access pipeline stage, directly downstream of EX and upstream of WB.
- Registers the EX→MEM bus under stall control and captures the synchronous data-SRAM read word.
- Performs load byte/halfword extraction and sign/zero extension, then selects the write-back value.
- Drives the MEM→WB bus and the MEM→RF forwarding bus.

---
 rtl/mem_stage_pkg.sv | 64 ++++++
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage_load_ext.sv | 41 ++++
 rtl/mem_stage.sv | 104 ++++++++++
 tb/tb_mem_stage.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: bus layouts, load opcodes,
// stall encoding and the read-data hold-buffer states.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 82;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_RF_WD = 38;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic {
    HOLD_IDLE,
    HOLD_HELD
  } hold_state_e;

  typedef struct packed {
    logic [5:0]  ld_st_op;
    logic [31:0] pc;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    ex_to_mem_t  ex;
    logic [1:0]  addr_lo;
  } mem_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } wb_bus_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } rf_bus_t;

  // Widens a byte or halfword to 32 bits; upper bits of v are ignored for bytes.
  function automatic logic [31:0] extend(input logic [15:0] v, input logic is_half,
                                         input logic is_signed);
    logic fill;
    if (is_half) begin
      fill = is_signed & v[15];
      return {{16{fill}}, v};
    end
    fill = is_signed & v[7];
    return {{24{fill}}, v[7:0]};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/SRAM -> MEM inputs and MEM -> WB/RF outputs of the memory stage, bundled for port use.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [1:0]              ex_addr_lo;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;

  modport master (
    output ex_to_mem_bus,
    output ex_addr_lo,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_rf_bus
  );

  modport slave (
    input  ex_to_mem_bus,
    input  ex_addr_lo,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_rf_bus
  );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Load data extraction: picks the addressed byte/halfword of the read word and
// sign- or zero-extends it; non-load opcodes yield zero.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [5:0]  ld_st_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
  end

  // Misaligned halfword addresses are not trapped; bit 0 simply does not matter here.
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  // NOTE: every output of a combinational block gets a value on every path (default
  // first); a path that leaves one unassigned infers a latch.
  always_comb begin
    data_o = '0;
    unique case (ld_st_op_i)
      OP_LB:   data_o = extend({8'h00, byte_sel}, 1'b0, 1'b1);
      OP_LBU:  data_o = extend({8'h00, byte_sel}, 1'b0, 1'b0);
      OP_LH:   data_o = extend(half_sel, 1'b1, 1'b1);
      OP_LHU:  data_o = extend(half_sel, 1'b1, 1'b0);
      OP_LW:   data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: stall-controlled EX->MEM register, synchronous-SRAM read-word
// hold buffer, load extension and write-back select driving the WB and forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  mem_stage_if.slave bus
);

  ex_to_mem_t  ex_in;
  mem_reg_t    mem_d, mem_q;
  hold_state_e state_d, state_q;
  logic [31:0] rdata_buf_d, rdata_buf_q;
  logic [31:0] word_sel, load_data, rf_wdata;
  logic        do_load, do_bubble, do_hold, is_read;
  wb_bus_t     wb_bus;
  rf_bus_t     rf_bus;
  logic        unused_stall;

  assign ex_in        = ex_to_mem_t'(bus.ex_to_mem_bus);
  assign unused_stall = ^{stall[5], stall[2:0]};

  // MEM stopped while WB runs means this stage must drain a bubble; both stopped holds.
  assign do_load   = (stall[3] == NO_STOP);
  assign do_bubble = (stall[3] == STOP) && (stall[4] == NO_STOP);
  assign do_hold   = (stall[3] == STOP) && (stall[4] == STOP);

  always_comb begin
    mem_d = mem_q;
    if (do_bubble) begin
      mem_d = '0;
    end else if (do_load) begin
      mem_d = '{ex: ex_in, addr_lo: bus.ex_addr_lo};
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign is_read = mem_q.ex.sram_en && (mem_q.ex.sram_wen == 4'b0000);

  // The SRAM presents read data for one cycle only, so a load stuck in MEM keeps a copy.
  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    unique case (state_q)
      HOLD_IDLE: begin
        if (do_hold && is_read) begin
          state_d     = HOLD_HELD;
          rdata_buf_d = bus.data_sram_rdata;
        end
      end
      HOLD_HELD: begin
        if (!do_hold) begin
          state_d = HOLD_IDLE;
        end
      end
      default: state_d = HOLD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD_IDLE;
      rdata_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign word_sel = (state_q == HOLD_HELD) ? rdata_buf_q : bus.data_sram_rdata;

  mem_stage_load_ext u_load_ext (
    .ld_st_op_i (mem_q.ex.ld_st_op),
    .addr_lo_i  (mem_q.addr_lo),
    .word_i     (word_sel),
    .data_o     (load_data)
  );

  assign rf_wdata = mem_q.ex.sel_rf_res ? load_data : mem_q.ex.ex_result;

  assign wb_bus = '{pc:       mem_q.ex.pc,
                    rf_we:    mem_q.ex.rf_we,
                    rf_waddr: mem_q.ex.rf_waddr,
                    rf_wdata: rf_wdata};

  assign rf_bus = '{rf_we:    mem_q.ex.rf_we,
                    rf_waddr: mem_q.ex.rf_waddr,
                    rf_wdata: rf_wdata};

  assign bus.mem_to_wb_bus = wb_bus;
  assign bus.mem_to_rf_bus = rf_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/hold/bubble/reset scenarios and a
// randomized stall/instruction run against a first-cycle-word reference model.
module tb_mem_stage;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc;
    logic        en;
    logic [3:0]  wen;
    logic        sel;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] res;
    logic [1:0]  alo;
  } instr_t;

  localparam logic [5:0] HOLD   = 6'b011111;
  localparam logic [5:0] BUBBLE = 6'b001000;
  localparam logic [5:0] RUN    = 6'b000000;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  instr_t      nxt, cur;
  logic [31:0] cur_word;

  function automatic instr_t zero_instr();
    instr_t i;
    i.op = '0; i.pc = '0; i.en = 1'b0; i.wen = '0; i.sel = 1'b0;
    i.we = 1'b0; i.waddr = '0; i.res = '0; i.alo = '0;
    return i;
  endfunction

  function automatic instr_t mk_load(input logic [5:0] op, input logic [4:0] waddr,
                                     input logic [1:0] alo);
    instr_t i = zero_instr();
    i.op = op; i.pc = $urandom; i.en = 1'b1; i.sel = 1'b1; i.we = 1'b1;
    i.waddr = waddr; i.res = $urandom; i.alo = alo;
    return i;
  endfunction

  function automatic instr_t mk_alu(input logic [31:0] res, input logic [4:0] waddr);
    instr_t i = zero_instr();
    i.op = 6'b000000; i.pc = $urandom; i.we = 1'b1; i.waddr = waddr; i.res = res;
    i.alo = 2'($urandom_range(0, 3));
    return i;
  endfunction

  function automatic instr_t mk_store(input logic [5:0] op);
    instr_t i = zero_instr();
    i.op = op; i.pc = $urandom; i.en = 1'b1; i.wen = 4'($urandom_range(1, 15));
    i.waddr = 5'($urandom); i.res = $urandom; i.alo = 2'($urandom_range(0, 3));
    return i;
  endfunction

  function automatic instr_t rand_instr();
    logic [5:0] loads [5] = '{6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011};
    logic [5:0] stores[3] = '{6'b101000, 6'b101001, 6'b101011};
    instr_t i;
    case ($urandom_range(0, 5))
      0, 1, 2: i = mk_load(loads[$urandom_range(0, 4)], 5'($urandom), 2'($urandom));
      3:       i = mk_store(stores[$urandom_range(0, 2)]);
      4:       i = mk_alu($urandom, 5'($urandom));
      default: begin
        i = mk_alu($urandom, 5'($urandom));
        i.sel = 1'b1;
        i.op = 6'b001111;
      end
    endcase
    return i;
  endfunction

  // Arithmetic view of load extension: shift the lane down, mask, fold the sign.
  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [1:0] alo,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    int          v;
    b = (w >> (8 * alo)) & 32'h0000_00FF;
    h = (w >> (alo[1] ? 16 : 0)) & 32'h0000_FFFF;
    case (op)
      6'b100000: begin v = int'(b); if (b > 127)   v = v - 256;   return 32'(v); end
      6'b100100: return b;
      6'b100001: begin v = int'(h); if (h > 32767) v = v - 65536; return 32'(v); end
      6'b100101: return h;
      6'b100011: return w;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata();
    return cur.sel ? ref_load(cur.op, cur.alo, cur_word) : cur.res;
  endfunction

  function automatic logic [69:0] exp_wb();
    return {cur.pc, cur.we, cur.waddr, exp_wdata()};
  endfunction

  function automatic logic [37:0] exp_rf();
    return {cur.we, cur.waddr, exp_wdata()};
  endfunction

  task automatic set_next(input instr_t i);
    nxt = i;
    ifc.ex_to_mem_bus = {i.op, i.pc, i.en, i.wen, i.sel, i.we, i.waddr, i.res};
    ifc.ex_addr_lo    = i.alo;
  endtask

  // One clock: model what MEM holds after the edge, then present this cycle's SRAM word.
  // A word only counts for an instruction in its first cycle in MEM.
  task automatic step(input logic [5:0] st, input logic [31:0] rdata_v);
    logic first;
    stall = st;
    @(posedge clk);
    first = 1'b1;
    if (rst)            cur = zero_instr();
    else if (!st[3])    cur = nxt;
    else if (!st[4])    cur = zero_instr();
    else                first = 1'b0;
    #1;
    ifc.data_sram_rdata = rdata_v;
    if (first) cur_word = rdata_v;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_next(rand_instr());
      step(6'($urandom), $urandom);
      checks++;
      if (ifc.mem_to_wb_bus !== 70'h0 || ifc.mem_to_rf_bus !== 38'h0) begin
        failures++;
        $display("FAIL reset_zero: wb=%h rf=%h expected all zero",
                 ifc.mem_to_wb_bus, ifc.mem_to_rf_bus);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_next(mk_load(6'b100011, 5'd9, 2'd0));
      step((k == 2) ? BUBBLE : HOLD, $urandom);
      checks++;
      if (ifc.mem_to_wb_bus !== 70'h0 || ifc.mem_to_rf_bus !== 38'h0) begin
        failures++;
        $display("FAIL post_reset_zero: wb=%h rf=%h expected all zero",
                 ifc.mem_to_wb_bus, ifc.mem_to_rf_bus);
      end
    end
  endtask

  task automatic test_loads_directed();
    logic [5:0]  ops [6] = '{6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100001};
    logic [1:0]  alos[6] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd0, 2'd3};
    logic [31:0] rd  [6] = '{32'h8765_4321, 32'h80FF_FFFF, 32'h80FF_FFFF, 32'h9234_0000,
                             32'h0000_8001, 32'h7FFF_0000};
    logic [31:0] exp [6] = '{32'h8765_4321, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_9234,
                             32'h0000_8001, 32'h0000_7FFF};
    for (int k = 0; k < 6; k++) begin
      set_next(mk_load(ops[k], 5'd5 + 5'(k), alos[k]));
      step(RUN, rd[k]);
      checks++;
      if (ifc.mem_to_wb_bus[37:0] !== {1'b1, 5'd5 + 5'(k), exp[k]} ||
          ifc.mem_to_wb_bus[69:38] !== nxt.pc ||
          ifc.mem_to_rf_bus !== ifc.mem_to_wb_bus[37:0]) begin
        failures++;
        $display("FAIL load_%0d op=%b: wb=%h rf=%h expected we=1 waddr=%0d wdata=%h",
                 k, ops[k], ifc.mem_to_wb_bus, ifc.mem_to_rf_bus, 5 + k, exp[k]);
      end
    end
  endtask

  task automatic test_hold();
    set_next(mk_load(6'b100011, 5'd7, 2'd0));
    step(RUN, 32'h1111_1111);
    set_next(mk_load(6'b100011, 5'd8, 2'd0));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(HOLD, (k == 1) ? 32'hDEAD_BEEF : $urandom);
      checks++;
      if (ifc.mem_to_wb_bus[37:0] !== {1'b1, 5'd7, 32'h1111_1111} ||
          ifc.mem_to_rf_bus !== {1'b1, 5'd7, 32'h1111_1111}) begin
        failures++;
        $display("FAIL hold_cycle_%0d: wb=%h rf=%h expected wdata=11111111 waddr=7",
                 k, ifc.mem_to_wb_bus, ifc.mem_to_rf_bus);
      end
    end
    step(RUN, 32'h2468_ACE0);
    checks++;
    if (ifc.mem_to_rf_bus !== {1'b1, 5'd8, 32'h2468_ACE0}) begin
      failures++;
      $display("FAIL hold_release: rf=%h expected %h", ifc.mem_to_rf_bus,
               {1'b1, 5'd8, 32'h2468_ACE0});
    end
  endtask

  task automatic test_bubble();
    set_next(mk_alu(32'h1234_5678, 5'd3));
    step(RUN, $urandom);
    step(BUBBLE, $urandom);
    checks++;
    if (ifc.mem_to_wb_bus !== 70'h0 || ifc.mem_to_rf_bus !== 38'h0) begin
      failures++;
      $display("FAIL bubble: wb=%h rf=%h expected all zero",
               ifc.mem_to_wb_bus, ifc.mem_to_rf_bus);
    end
  endtask

  task automatic test_alu_store();
    set_next(mk_alu(32'h0000_00AB, 5'd12));
    step(RUN, $urandom);
    checks++;
    if (ifc.mem_to_wb_bus[37:0] !== {1'b1, 5'd12, 32'h0000_00AB} ||
        ifc.mem_to_rf_bus !== {1'b1, 5'd12, 32'h0000_00AB}) begin
      failures++;
      $display("FAIL alu: wb=%h rf=%h expected wdata=000000ab", ifc.mem_to_wb_bus,
               ifc.mem_to_rf_bus);
    end
    set_next(mk_store(6'b101011));
    step(RUN, $urandom);
    checks++;
    if (ifc.mem_to_wb_bus[37] !== 1'b0 || ifc.mem_to_rf_bus[37] !== 1'b0 ||
        ifc.mem_to_wb_bus[31:0] !== nxt.res) begin
      failures++;
      $display("FAIL store: wb=%h rf=%h expected rf_we=0 wdata=%h", ifc.mem_to_wb_bus,
               ifc.mem_to_rf_bus, nxt.res);
    end
  endtask

  task automatic test_reset_mid_hold();
    set_next(mk_load(6'b100011, 5'd20, 2'd1));
    step(RUN, 32'h1234_5678);
    step(HOLD, 32'hCAFE_F00D);
    rst = 1'b1;
    step(HOLD, 32'h0BAD_0BAD);
    checks++;
    if (ifc.mem_to_wb_bus !== 70'h0 || ifc.mem_to_rf_bus !== 38'h0) begin
      failures++;
      $display("FAIL reset_mid_hold: wb=%h rf=%h expected all zero",
               ifc.mem_to_wb_bus, ifc.mem_to_rf_bus);
    end
    rst = 1'b0;
    set_next(mk_load(6'b100011, 5'd21, 2'd0));
    step(RUN, 32'h5555_AAAA);
    checks++;
    if (ifc.mem_to_rf_bus !== {1'b1, 5'd21, 32'h5555_AAAA}) begin
      failures++;
      $display("FAIL reload_after_reset: rf=%h expected %h", ifc.mem_to_rf_bus,
               {1'b1, 5'd21, 32'h5555_AAAA});
    end
  endtask

  task automatic test_random();
    logic [5:0] st;
    for (int k = 0; k < 400; k++) begin
      set_next(rand_instr());
      st = 6'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    st[3] = 1'b0;
        2:       begin st[3] = 1'b1; st[4] = 1'b0; end
        default: begin st[3] = 1'b1; st[4] = 1'b1; end
      endcase
      rst = ($urandom_range(0, 49) == 0);
      step(st, $urandom);
      checks++;
      if (ifc.mem_to_wb_bus !== exp_wb() || ifc.mem_to_rf_bus !== exp_rf()) begin
        failures++;
        $display("FAIL random_%0d stall=%b rst=%b: wb=%h rf=%h expected wb=%h rf=%h",
                 k, st, rst, ifc.mem_to_wb_bus, ifc.mem_to_rf_bus, exp_wb(), exp_rf());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    stall               = '0;
    ifc.ex_to_mem_bus   = '0;
    ifc.ex_addr_lo      = '0;
    ifc.data_sram_rdata = '0;
    cur                 = zero_instr();
    nxt                 = zero_instr();
    cur_word            = '0;
    test_reset();
    test_loads_directed();
    test_hold();
    test_bubble();
    test_alu_store();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
